agex_stage: RTL and testbench

Address-generation / execute stage of the five-stage RV32I pipeline, directly downstream of decode: it consumes the decode pipeline latch and produces the execute latch read by the memory stage. It computes ALU results, load/store addresses and store data, and resolves every branch and jump. It returns a redirect to fetch and hazard/stall information to decode. MUL runs on an iterative 32-cycle shift-add unit that stalls decode while busy.

---
 rtl/agex_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_agex_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agex_stage.sv
// Address-generation / execute stage of the RV32I pipeline: ALU, branch/jump resolution,
// load/store address generation and a 32-cycle iterative shift-add multiplier.
module agex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [4:0]      in_op,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_wr_reg,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_wr_reg,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic [XLEN-1:0] out_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall_de,
  output logic [4:0]      agex_rd,
  output logic            agex_wr
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [4:0] OpAdd   = 5'd0;
  localparam logic [4:0] OpSub   = 5'd1;
  localparam logic [4:0] OpAnd   = 5'd2;
  localparam logic [4:0] OpOr    = 5'd3;
  localparam logic [4:0] OpXor   = 5'd4;
  localparam logic [4:0] OpSlt   = 5'd5;
  localparam logic [4:0] OpSltu  = 5'd6;
  localparam logic [4:0] OpSra   = 5'd7;
  localparam logic [4:0] OpSrl   = 5'd8;
  localparam logic [4:0] OpSll   = 5'd9;
  localparam logic [4:0] OpMul   = 5'd10;
  localparam logic [4:0] OpLui   = 5'd11;
  localparam logic [4:0] OpAuipc = 5'd12;
  localparam logic [4:0] OpJal   = 5'd13;
  localparam logic [4:0] OpJalr  = 5'd14;
  localparam logic [4:0] OpBeq   = 5'd15;
  localparam logic [4:0] OpBne   = 5'd16;
  localparam logic [4:0] OpBlt   = 5'd17;
  localparam logic [4:0] OpBge   = 5'd18;
  localparam logic [4:0] OpBltu  = 5'd19;
  localparam logic [4:0] OpBgeu  = 5'd20;
  localparam logic [4:0] OpLw    = 5'd21;
  localparam logic [4:0] OpSw    = 5'd22;

  typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [4:0]      mul_rd_q, mul_rd_d;
  logic            mul_wr_q, mul_wr_d;
  logic [XLEN-1:0] mul_pc_q, mul_pc_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [XLEN-1:0] out_store_data_q, out_store_data_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_wr_reg_q, out_wr_reg_d;
  logic            out_is_load_q, out_is_load_d;
  logic            out_is_store_q, out_is_store_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic            accept, accept_mul, is_branch, is_jump, taken;
  logic [XLEN-1:0] op_b, alu_res, pc_plus4, target, acc_next;
  logic [4:0]      shamt;

  always_comb begin
    op_b      = in_use_imm ? in_imm : in_rs2_val;
    shamt     = op_b[4:0];
    pc_plus4  = in_pc + XLEN'(4);
    accept    = in_valid && (state_q == StIdle) && (in_op <= OpSw);
    accept_mul = accept && (in_op == OpMul);
    is_branch = (in_op >= OpBeq) && (in_op <= OpBgeu);
    is_jump   = (in_op == OpJal) || (in_op == OpJalr);

    alu_res = '0;
    unique case (in_op)
      OpAdd:            alu_res = in_rs1_val + op_b;
      OpSub:            alu_res = in_rs1_val - op_b;
      OpAnd:            alu_res = in_rs1_val & op_b;
      OpOr:             alu_res = in_rs1_val | op_b;
      OpXor:            alu_res = in_rs1_val ^ op_b;
      OpSlt:            alu_res = XLEN'($signed(in_rs1_val) < $signed(op_b));
      OpSltu:           alu_res = XLEN'(in_rs1_val < op_b);
      OpSra:            alu_res = $unsigned($signed(in_rs1_val) >>> shamt);
      OpSrl:            alu_res = in_rs1_val >> shamt;
      OpSll:            alu_res = in_rs1_val << shamt;
      OpLui:            alu_res = in_imm;
      OpAuipc:          alu_res = in_pc + in_imm;
      OpJal, OpJalr:    alu_res = pc_plus4;
      OpLw, OpSw:       alu_res = in_rs1_val + in_imm;
      default:          alu_res = '0;
    endcase

    // Branch compares always use rs2; in_use_imm only selects I-type ALU operands.
    taken = 1'b0;
    unique case (in_op)
      OpBeq:   taken = (in_rs1_val == in_rs2_val);
      OpBne:   taken = (in_rs1_val != in_rs2_val);
      OpBlt:   taken = ($signed(in_rs1_val) < $signed(in_rs2_val));
      OpBge:   taken = ($signed(in_rs1_val) >= $signed(in_rs2_val));
      OpBltu:  taken = (in_rs1_val < in_rs2_val);
      OpBgeu:  taken = (in_rs1_val >= in_rs2_val);
      default: taken = 1'b0;
    endcase

    if (in_op == OpJalr) begin
      target = (in_rs1_val + in_imm) & ~XLEN'(1);
    end else begin
      target = in_pc + in_imm;
    end

    acc_next = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_rd_d = mul_rd_q;
    mul_wr_d = mul_wr_q;
    mul_pc_d = mul_pc_q;

    out_valid_d      = 1'b0;
    out_result_d     = '0;
    out_store_data_d = '0;
    out_rd_d         = '0;
    out_wr_reg_d     = 1'b0;
    out_is_load_d    = 1'b0;
    out_is_store_d   = 1'b0;
    out_pc_d         = '0;

    if (state_q == StMulBusy) begin
      acc_d = acc_next;
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(XLEN - 1)) begin
        state_d      = StIdle;
        out_valid_d  = 1'b1;
        out_result_d = acc_next;
        out_rd_d     = mul_rd_q;
        out_wr_reg_d = mul_wr_q && (mul_rd_q != 5'd0);
        out_pc_d     = mul_pc_q;
      end
    end else if (accept_mul) begin
      state_d  = StMulBusy;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = in_rs1_val;
      mplier_d = in_rs2_val;
      mul_rd_d = in_rd;
      mul_wr_d = in_wr_reg;
      mul_pc_d = in_pc;
    end else if (accept) begin
      out_valid_d      = 1'b1;
      out_result_d     = is_branch ? '0 : alu_res;
      out_store_data_d = (in_op == OpSw) ? in_rs2_val : '0;
      out_rd_d         = in_rd;
      out_wr_reg_d     = in_wr_reg && (in_rd != 5'd0);
      out_is_load_d    = (in_op == OpLw);
      out_is_store_d   = (in_op == OpSw);
      out_pc_d         = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      acc_q            <= '0;
      mcand_q          <= '0;
      mplier_q         <= '0;
      mul_rd_q         <= '0;
      mul_wr_q         <= 1'b0;
      mul_pc_q         <= '0;
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_store_data_q <= '0;
      out_rd_q         <= '0;
      out_wr_reg_q     <= 1'b0;
      out_is_load_q    <= 1'b0;
      out_is_store_q   <= 1'b0;
      out_pc_q         <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      acc_q            <= acc_d;
      mcand_q          <= mcand_d;
      mplier_q         <= mplier_d;
      mul_rd_q         <= mul_rd_d;
      mul_wr_q         <= mul_wr_d;
      mul_pc_q         <= mul_pc_d;
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_store_data_q <= out_store_data_d;
      out_rd_q         <= out_rd_d;
      out_wr_reg_q     <= out_wr_reg_d;
      out_is_load_q    <= out_is_load_d;
      out_is_store_q   <= out_is_store_d;
      out_pc_q         <= out_pc_d;
    end
  end

  // Control outputs to fetch/decode are gated by reset so they read 0 while it is held.
  always_comb begin
    out_valid      = out_valid_q;
    out_result     = out_result_q;
    out_store_data = out_store_data_q;
    out_rd         = out_rd_q;
    out_wr_reg     = out_wr_reg_q;
    out_is_load    = out_is_load_q;
    out_is_store   = out_is_store_q;
    out_pc         = out_pc_q;

    redirect_valid = !reset && accept && (is_branch || is_jump);
    redirect_pc    = (is_jump || taken) ? target : pc_plus4;
    stall_de       = !reset && ((state_q == StMulBusy) || accept_mul);

    if (state_q == StMulBusy) begin
      agex_rd = mul_rd_q;
      agex_wr = !reset && mul_wr_q && (mul_rd_q != 5'd0);
    end else begin
      agex_rd = in_rd;
      agex_wr = !reset && in_valid && in_wr_reg && (in_rd != 5'd0);
    end
  end

endmodule

// File: tb/tb_agex_stage.sv
// Self-checking bench for agex_stage: directed cases, randomized ALU/branch/memory ops against
// an arithmetic reference model, multiply timing, reset abort and back-to-back multiplies.
module tb_agex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_op;
  logic        in_use_imm;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rd;
  logic        in_wr_reg;
  logic        out_valid;
  logic [31:0] out_result, out_store_data, out_pc;
  logic [4:0]  out_rd;
  logic        out_wr_reg, out_is_load, out_is_store;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_de;
  logic [4:0]  agex_rd;
  logic        agex_wr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  agex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_use_imm(in_use_imm),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rd(in_rd), .in_wr_reg(in_wr_reg), .out_valid(out_valid), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_wr_reg(out_wr_reg),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_de(stall_de),
    .agex_rd(agex_rd), .agex_wr(agex_wr)
  );

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic        chk_res;
    logic [31:0] sd;
    logic        chk_sd;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        st;
    logic [31:0] pc;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  // Reference model for a single non-MUL instruction, straight from the ISA rules.
  function automatic exp_t model(input logic v, input logic [4:0] op, input logic ui,
                                 input logic [31:0] pc, a, r2, imm, input logic [4:0] rd,
                                 input logic wr);
    exp_t e;
    logic [31:0] b;
    int unsigned sh;
    logic tk;
    e = '{valid: 1'b0, result: '0, chk_res: 1'b1, sd: '0, chk_sd: 1'b1, rd: '0, wr: 1'b0,
          ld: 1'b0, st: 1'b0, pc: '0, redir: 1'b0, rpc: '0};
    if (!v || op > 5'd22 || op == 5'd10) return e;
    b  = ui ? imm : r2;
    sh = b % 32;
    e.valid = 1'b1; e.rd = rd; e.wr = wr && (rd != 0); e.pc = pc; e.chk_sd = 1'b0;
    case (op)
      5'd0:  e.result = a + b;
      5'd1:  e.result = a - b;
      5'd2:  e.result = a & b;
      5'd3:  e.result = a | b;
      5'd4:  e.result = a ^ b;
      5'd5:  e.result = (int'(a) < int'(b)) ? 32 'd1 : 32'd0;
      5'd6:  e.result = (a < b) ? 32'd1 : 32'd0;
      5'd7:  e.result = 32'(longint'(int'(a)) / (64'sd1 <<< sh)
                        - ((int'(a) < 0 && (a % (32'd1 << sh)) != 0) ? 1 : 0));
      5'd8:  e.result = a / (33'd1 << sh);
      5'd9:  e.result = 32'(64'(a) * (64'd1 << sh));
      5'd11: e.result = imm;
      5'd12: e.result = pc + imm;
      5'd13: begin e.result = pc + 4; e.redir = 1'b1; e.rpc = pc + imm; end
      5'd14: begin e.result = pc + 4; e.redir = 1'b1; e.rpc = (a + imm) - ((a + imm) % 2); end
      5'd21: begin e.result = a + imm; e.ld = 1'b1; end
      5'd22: begin e.result = a + imm; e.st = 1'b1; e.sd = r2; e.chk_sd = 1'b1; end
      default: begin
        case (op)
          5'd15: tk = (a == r2);
          5'd16: tk = (a != r2);
          5'd17: tk = int'(a) < int'(r2);
          5'd18: tk = int'(a) >= int'(r2);
          5'd19: tk = a < r2;
          default: tk = a >= r2;
        endcase
        e.chk_res = 1'b0; e.redir = 1'b1; e.rpc = tk ? pc + imm : pc + 4;
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rval();
    logic [31:0] corners[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h21};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  task automatic drive(input logic v, input logic [4:0] op, input logic ui, input logic [31:0] pc,
                       input logic [31:0] a, b, imm, input logic [4:0] rd, input logic wr);
    in_valid = v; in_op = op; in_use_imm = ui; in_pc = pc; in_rs1_val = a; in_rs2_val = b;
    in_imm = imm; in_rd = rd; in_wr_reg = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 5'd15, 0, 32'h100, 32'h5, 32'h5, 32'h40, 5'd5, 1);
    tick(); tick();
    #1;
    checks++;
    if ({out_valid, out_result, out_store_data, out_rd, out_wr_reg, out_is_load, out_is_store,
         out_pc} !== '0) begin
      errors++; $display("FAIL reset_latch got valid=%b result=%h pc=%h required all zero",
                         out_valid, out_result, out_pc);
    end
    checks++;
    if (redirect_valid !== 1'b0 || agex_wr !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got redirect=%b agex_wr=%b required 0 0",
                         redirect_valid, agex_wr);
    end
    drive(1, 5'd10, 0, 32'h0, 32'h3, 32'h3, 32'h0, 5'd7, 1);
    #1;
    checks++;
    if (stall_de !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b required 0", stall_de);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_directed();
    drive(1, 5'd0, 1, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h1, 5'd5, 1);
    tick();
    checks++;
    if (out_result !== 32'h80000000 || out_rd !== 5'd5 || out_wr_reg !== 1'b1 ||
        out_valid !== 1'b1) begin
      errors++; $display("FAIL addi got result=%h rd=%0d wr=%b required 80000000 5 1",
                         out_result, out_rd, out_wr_reg);
    end
    drive(1, 5'd16, 0, 32'h100, 32'h3, 32'h3, 32'h40, 5'd0, 0);
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
      errors++; $display("FAIL bne_not_taken got %b/%h required 1/00000104",
                         redirect_valid, redirect_pc);
    end
    in_rs2_val = 32'h4;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h140) begin
      errors++; $display("FAIL bne_taken got %b/%h required 1/00000140",
                         redirect_valid, redirect_pc);
    end
    tick();
    drive(1, 5'd14, 0, 32'h200, 32'h1001, 32'h0, 32'h2, 5'd1, 1);
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1002) begin
      errors++; $display("FAIL jalr_target got %b/%h required 1/00001002",
                         redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if (out_result !== 32'h204) begin
      errors++; $display("FAIL jalr_link got %h required 00000204", out_result);
    end
    drive(1, 5'd19, 0, 32'h300, 32'hFFFFFFFF, 32'h1, 32'h80, 5'd0, 0);
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin
      errors++; $display("FAIL bltu_not_taken got %b/%h required 1/00000304",
                         redirect_valid, redirect_pc);
    end
    tick();
    drive(1, 5'd7, 0, 32'h0, 32'h80000000, 32'h21, 32'h0, 5'd2, 1);
    tick();
    checks++;
    if (out_result !== 32'hC0000000) begin
      errors++; $display("FAIL sra got %h required c0000000", out_result);
    end
    drive(1, 5'd5, 0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd2, 1);
    tick();
    checks++;
    if (out_result !== 32'h1) begin
      errors++; $display("FAIL slt got %h required 00000001", out_result);
    end
    drive(1, 5'd22, 0, 32'h40, 32'h1000, 32'hCAFE, 32'h8, 5'd0, 1);
    #1;
    checks++;
    if (agex_wr !== 1'b0) begin
      errors++; $display("FAIL sw_agex_wr got %b required 0", agex_wr);
    end
    tick();
    checks++;
    if (out_is_store !== 1'b1 || out_wr_reg !== 1'b0 || out_result !== 32'h1008 ||
        out_store_data !== 32'hCAFE) begin
      errors++; $display("FAIL sw got st=%b wr=%b addr=%h data=%h required 1 0 00001008 0000cafe",
                         out_is_store, out_wr_reg, out_result, out_store_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    exp_t m;
    logic [4:0] op;
    for (int i = 0; i < 300; i++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'd10);
      drive($urandom_range(0, 9) != 0, op, 1'($urandom), rval(), rval(), rval(), rval(),
            5'($urandom), 1'($urandom));
      m = model(in_valid, in_op, in_use_imm, in_pc, in_rs1_val, in_rs2_val, in_imm, in_rd,
                in_wr_reg);
      #1;
      checks++;
      if (redirect_valid !== m.redir || (m.redir && redirect_pc !== m.rpc)) begin
        errors++; $display("FAIL rand_redirect op=%0d got %b/%h required %b/%h", op,
                           redirect_valid, redirect_pc, m.redir, m.rpc);
      end
      checks++;
      if (stall_de !== 1'b0 || agex_rd !== in_rd ||
          agex_wr !== (in_valid && in_wr_reg && in_rd != 0)) begin
        errors++; $display("FAIL rand_hazard op=%0d got stall=%b rd=%0d wr=%b", op, stall_de,
                           agex_rd, agex_wr);
      end
      tick();
      checks++;
      if (out_valid !== m.valid || out_rd !== m.rd || out_wr_reg !== m.wr ||
          out_is_load !== m.ld || out_is_store !== m.st || out_pc !== m.pc ||
          (m.chk_res && out_result !== m.result) || (m.chk_sd && out_store_data !== m.sd)) begin
        errors++;
        $display("FAIL rand_latch op=%0d got v=%b res=%h sd=%h rd=%0d wr=%b ld=%b st=%b pc=%h required v=%b res=%h sd=%h rd=%0d wr=%b ld=%b st=%b pc=%h",
                 op, out_valid, out_result, out_store_data, out_rd, out_wr_reg, out_is_load,
                 out_is_store, out_pc, m.valid, m.result, m.sd, m.rd, m.wr, m.ld, m.st, m.pc);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_mul(input logic [31:0] a, b, input logic [4:0] rd);
    logic [31:0] prod;
    int stall_cycles, early_valid;
    prod = 32'(64'(a) * 64'(b));
    stall_cycles = 0; early_valid = 0;
    drive(1, 5'd10, 0, 32'h500, a, b, 32'h0, rd, 1);
    #1;
    if (stall_de === 1'b1) stall_cycles++;
    checks++;
    if (redirect_valid !== 1'b0 || agex_wr !== (rd != 0)) begin
      errors++; $display("FAIL mul_accept got redirect=%b agex_wr=%b", redirect_valid, agex_wr);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 32; k++) begin
      #1;
      if (stall_de === 1'b1) stall_cycles++;
      if (out_valid !== 1'b0) early_valid++;
      if (k == 16) begin
        checks++;
        if (agex_rd !== rd || agex_wr !== (rd != 0)) begin
          errors++; $display("FAIL mul_busy_agex got rd=%0d wr=%b required %0d %b", agex_rd,
                             agex_wr, rd, rd != 0);
        end
      end
      tick();
    end
    checks++;
    if (stall_cycles != 33 || stall_de !== 1'b0) begin
      errors++; $display("FAIL mul_stall got %0d cycles, final %b required 33 cycles, final 0",
                         stall_cycles, stall_de);
    end
    checks++;
    if (early_valid != 0) begin
      errors++; $display("FAIL mul_bubbles got %0d valid cycles required 0", early_valid);
    end
    checks++;
    if (out_valid !== 1'b1 || out_result !== prod || out_rd !== rd ||
        out_wr_reg !== (rd != 0) || out_pc !== 32'h500) begin
      errors++; $display("FAIL mul_result got v=%b %h rd=%0d pc=%h required 1 %h %0d 00000500",
                         out_valid, out_result, out_rd, out_pc, prod, rd);
    end
    tick();
  endtask

  task automatic test_mul_reset();
    int late_valid;
    late_valid = 0;
    drive(1, 5'd10, 0, 32'h600, 32'h1234, 32'h5678, 32'h0, 5'd9, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (stall_de !== 1'b0 || agex_wr !== 1'b0) begin
      errors++; $display("FAIL mulrst_ctrl got stall=%b agex_wr=%b required 0 0", stall_de,
                         agex_wr);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || stall_de !== 1'b0) begin
      errors++; $display("FAIL mulrst_state got v=%b res=%h stall=%b required 0 0 0", out_valid,
                         out_result, stall_de);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0 || stall_de !== 1'b0) late_valid++;
    end
    checks++;
    if (late_valid != 0) begin
      errors++; $display("FAIL mulrst_no_result got %0d bad cycles required 0", late_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 5'd10, 0, 32'h700, 32'd7, 32'd6, 32'h0, 5'd3, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (32) tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd42) begin
      errors++; $display("FAIL b2b_first got v=%b %h required 1 0000002a", out_valid, out_result);
    end
    drive(1, 5'd10, 0, 32'h704, 32'h10000, 32'h10001, 32'h0, 5'd4, 1);
    #1;
    checks++;
    if (stall_de !== 1'b1) begin
      errors++; $display("FAIL b2b_stall got %b required 1", stall_de);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (32) tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h00010000 || out_rd !== 5'd4) begin
      errors++; $display("FAIL b2b_second got v=%b %h rd=%0d required 1 00010000 4", out_valid,
                         out_result, out_rd);
    end
    drive(1, 5'd1, 0, 32'h708, 32'h5, 32'h7, 32'h0, 5'd6, 1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL b2b_sub got v=%b %h required 1 fffffffe", out_valid, out_result);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_directed();
    test_random();
    test_mul(32'hFFFFFFFF, 32'd3, 5'd8);
    test_mul($urandom, $urandom, 5'd0);
    test_mul($urandom, 32'h80000001, 5'd31);
    test_mul_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
